// File: rtl/argument_pkg.sv
// Shared encodings and defaults for the multi-channel angle accumulator.
package argument_pkg;
  localparam int DEF_PI_URAD = 3141593;

  localparam logic [1:0] OP_ACC  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;

  typedef enum logic [1:0] {IDLE, ADD, NORM} state_t;
endpackage

// File: rtl/argument_calc_mc_uc.sv
// Control unit: command sequencing, normalisation step limit and busy/done/err.
module argument_calc_mc_uc
  import argument_pkg::*;
#(
  parameter int MAX_NORM_ITER = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  logic   ch_ok,
  input  logic   in_range,
  output state_t state,
  output logic   busy,
  output logic   done,
  output logic   err
);
  localparam int IW = $clog2(MAX_NORM_ITER + 2);

  logic [IW-1:0] iter;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      iter  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ADD;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        ADD: begin
          iter <= '0;
          if (ch_ok) begin
            state <= NORM;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        NORM: begin
          if (in_range) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (iter == IW'(MAX_NORM_ITER)) begin
            // Correction budget exhausted while still out of range: abort without a write.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/argument_calc_mc.sv
// Multi-channel microradian angle accumulator; results normalised into [-PI, PI).
module argument_calc_mc
  import argument_pkg::*;
#(
  parameter  int WIDTH         = 64,
  parameter  int CHANNELS      = 4,
  parameter  int PI_URAD       = DEF_PI_URAD,
  parameter  int MAX_NORM_ITER = 8,
  localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic [CW-1:0]           ch,
  input  logic signed [WIDTH-1:0] theta,
  input  logic signed [WIDTH-1:0] delta_theta,
  output logic signed [WIDTH-1:0] argument,
  output logic [CW-1:0]           arg_ch,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam logic signed [WIDTH-1:0] PI_W     = $signed(WIDTH'(PI_URAD));
  localparam logic signed [WIDTH-1:0] TWO_PI_W = $signed(WIDTH'(2 * PI_URAD));

  state_t                  state;
  logic [1:0]              op_q;
  logic [CW-1:0]           ch_q;
  logic signed [WIDTH-1:0] theta_q;
  logic signed [WIDTH-1:0] delta_q;
  logic signed [WIDTH-1:0] work;
  logic signed [WIDTH-1:0] arg [CHANNELS];
  logic signed [WIDTH-1:0] arg_base;
  logic                    ch_ok;
  logic                    in_range;

  function automatic logic signed [WIDTH-1:0] norm_step(input logic signed [WIDTH-1:0] v);
    if (v >= PI_W)  return v - TWO_PI_W;
    if (v < -PI_W)  return v + TWO_PI_W;
    return v;
  endfunction

  assign ch_ok    = int'(ch_q) < CHANNELS;
  assign in_range = (work < PI_W) && (work >= -PI_W);

  // Out-of-range channels read as zero; they never reach a write.
  always_comb begin
    arg_base = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (ch_q == CW'(i)) arg_base = arg[i];
  end

  argument_calc_mc_uc #(.MAX_NORM_ITER(MAX_NORM_ITER)) u_uc (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ch_ok    (ch_ok),
    .in_range (in_range),
    .state    (state),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_ACC;
      ch_q     <= '0;
      theta_q  <= '0;
      delta_q  <= '0;
      work     <= '0;
      argument <= '0;
      arg_ch   <= '0;
      for (int i = 0; i < CHANNELS; i++) arg[i] <= '0;
    end else begin
      if (state == IDLE && start) begin
        op_q    <= op;
        ch_q    <= ch;
        theta_q <= theta;
        delta_q <= delta_theta;
      end
      // ADD stage: form the raw result; reserved op falls through to accumulate
      if (state == ADD) begin
        case (op_q)
          OP_LOAD: work <= theta_q + delta_q;
          OP_CLR:  work <= '0;
          default: work <= arg_base + delta_q;
        endcase
      end
      // NORM stage: commit when in range, otherwise apply one 2*PI correction
      if (state == NORM) begin
        if (in_range) begin
          for (int i = 0; i < CHANNELS; i++)
            if (ch_q == CW'(i)) arg[i] <= work;
          argument <= work;
          arg_ch   <= ch_q;
        end else begin
          work <= norm_step(work);
        end
      end
    end
  end
endmodule

// File: tb/tb_argument_calc_mc.sv
// Directed bench for argument_calc_mc with hand-computed results (3 channels, 4-step limit).
module tb_argument_calc_mc;
  logic               clk;
  logic               reset;
  logic               start;
  logic [1:0]         op;
  logic [1:0]         ch;
  logic signed [63:0] theta;
  logic signed [63:0] delta_theta;
  logic signed [63:0] argument;
  logic [1:0]         arg_ch;
  logic               busy;
  logic               done;
  logic               err;

  int total = 0;
  int bad   = 0;

  argument_calc_mc #(
    .WIDTH(64), .CHANNELS(3), .PI_URAD(3141593), .MAX_NORM_ITER(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .ch          (ch),
    .theta       (theta),
    .delta_theta (delta_theta),
    .argument    (argument),
    .arg_ch      (arg_ch),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " done_seen"}, 64'(done), 1);
  endtask

  task automatic cmd(input string tag, input logic [1:0] o, input logic [1:0] c,
                     input longint t, input longint d, input longint exp_arg,
                     input int exp_ch, input int exp_err, input int exp_lat);
    int lat;
    op = o; ch = c; theta = t; delta_theta = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy"}, 64'(busy), 1);
    wait_done(tag, lat);
    chk({tag, " arg"}, argument, exp_arg);
    chk({tag, " ch"}, 64'(arg_ch), 64'(exp_ch));
    chk({tag, " err"}, 64'(err), 64'(exp_err));
    chk({tag, " lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, " idle"}, 64'(busy), 0);
  endtask

  initial begin
    int lat;
    reset = 1'b0; start = 1'b0; op = 2'b00; ch = 2'd0; theta = '0; delta_theta = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = 1'($urandom); op = 2'($urandom); ch = 2'($urandom);
      theta = {$urandom, $urandom}; delta_theta = {$urandom, $urandom};
    end
    chk("rst arg", argument, 0);
    chk("rst ch", 64'(arg_ch), 0);
    chk("rst busy", 64'(busy), 0);
    chk("rst done", 64'(done), 0);
    chk("rst err", 64'(err), 0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    cmd("acc2",  2'b00, 2'd2, 0,        0,        0,        2, 0, 2);
    cmd("load0", 2'b01, 2'd0, 1000000,  500000,   1500000,  0, 0, 2);
    cmd("wrap",  2'b00, 2'd0, 0,        2000000,  -2783186, 0, 0, 3);
    cmd("load1", 2'b01, 2'd1, -3000000, -500000,  2783186,  1, 0, 3);
    cmd("iso0",  2'b00, 2'd0, 0,        0,        -2783186, 0, 0, 2);
    cmd("pi",    2'b01, 2'd2, 3141593,  0,        -3141593, 2, 0, 3);
    cmd("mpi",   2'b01, 2'd2, -3141593, 0,        -3141593, 2, 0, 2);
    cmd("clr1",  2'b10, 2'd1, 5,        5,        0,        1, 0, 2);
    cmd("rsv",   2'b11, 2'd1, 77,       100,      100,      1, 0, 2);
    cmd("iter",  2'b01, 2'd0, 40000000, 0,        100,      1, 1, 6);
    cmd("post",  2'b00, 2'd0, 0,        0,        -2783186, 0, 0, 2);
    cmd("badch", 2'b00, 2'd3, 0,        5,        -2783186, 0, 1, 1);

    // A second start held high while busy must be dropped.
    op = 2'b01; ch = 2'd0; theta = 7; delta_theta = 0; start = 1'b1;
    @(posedge clk); #1;
    ch = 2'd1; theta = 999;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign", lat);
    chk("ign arg", argument, 7);
    chk("ign ch", 64'(arg_ch), 0);
    chk("ign err", 64'(err), 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("ign done1", 64'(done), 0);
    chk("ign busy", 64'(busy), 0);
    cmd("iso1",  2'b00, 2'd1, 0,        0,        100,      1, 0, 2);

    // Reset in the middle of a normalisation sequence.
    op = 2'b01; ch = 2'd0; theta = 40000000; delta_theta = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid busy", 64'(busy), 1);
    reset = 1'b0;
    #1;
    chk("mid arg", argument, 0);
    chk("mid ch", 64'(arg_ch), 0);
    chk("mid busy0", 64'(busy), 0);
    chk("mid done", 64'(done), 0);
    chk("mid err", 64'(err), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    cmd("rst0",  2'b00, 2'd0, 0,        0,        0,        0, 0, 2);
    cmd("rst1",  2'b00, 2'd1, 0,        0,        0,        1, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/argument_calc_mc.md
# argument_calc_mc

Multi-channel angle accumulator with normalisation, the parametrised successor to the single-channel argument calculator in the Cyclone Cruiser trajectory path. It holds one signed microradian angle per channel. On each accepted command it either accumulates a delta, loads theta+delta, or clears the channel. It then normalises the result into [-PI, PI) with an iterative corrector, and reports the result with a done/err handshake.

## Interface
Parameters:
- WIDTH, 64, signed data width of angles (microradians)
- CHANNELS, 4, number of independent angle registers (≥1)
- PI_URAD, 3141593, PI in microradians; 2·PI derived internally as 2*PI_URAD
- MAX_NORM_ITER, 8, maximum correction steps before err

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  command request, sampled only in IDLE
- op  in  2  00 accumulate, 01 load, 10 clear, 11 reserved (treated as accumulate)
- ch  in  max(1,$clog2(CHANNELS))  target channel
- theta  in  WIDTH signed  load base angle
- delta_theta  in  WIDTH signed  angle increment
- argument  out  WIDTH signed  last normalised result written
- arg_ch  out  max(1,$clog2(CHANNELS))  channel of last result
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle completion pulse
- err  out  1  error flag for last command, valid with done, held until next accepted start

## Operation
- States: IDLE, ADD, NORM.
- IDLE: start=1 latches op, ch, theta, delta_theta, clears err, and moves to ADD.
- ADD: work <= arg[ch]+delta (accumulate), theta+delta (load) or 0 (clear). Moves to NORM.
  - If ch ≥ CHANNELS: done=1, err=1, no write, return to IDLE.
- NORM, one step per cycle:
  - work ≥ PI_URAD: work -= 2·PI
  - work < -PI_URAD: work += 2·PI
  - in range: arg[ch] <= work, argument <= work, arg_ch <= ch, done=1, return to IDLE.
- Iteration limit: if MAX_NORM_ITER corrections are applied and work is still out of range, the block asserts done=1 and err=1. arg[ch], argument and arg_ch stay unchanged. It returns to IDLE.
- Arithmetic is WIDTH bits, two's complement. Callers keep |theta|, |delta_theta| < 2^(WIDTH-2); overflow is not detected.
- Boundaries:
  - PI_URAD normalises to -PI_URAD.
  - -PI_URAD is kept as is.
- start while busy is ignored; no queueing.
- Reserved op 11 behaves exactly as accumulate.

## Timing
- Reset: all arg[], argument, arg_ch, work, busy, done, err = 0; state IDLE. Reset mid-command drops the command, with no partial write.
- Start accepted at edge E0.
- ADD executes at E1.
- The first NORM evaluation is at E2. With k corrections, done is high in the cycle after edge E2+k (k=0 → done 2 cycles after acceptance).
- busy is high from after E0 through the ADD/NORM cycles and falls together with the done rise.
- done lasts exactly one cycle.
- start sampled high in the done cycle is accepted (back-to-back commands, no bubble).
- argument/arg_ch update in the same cycle done rises. They hold otherwise.

## Structure
- Package argument_pkg holds:
  - op encodings (OP_ACC, OP_LOAD, OP_CLR)
  - state enum (IDLE, ADD, NORM)
  - default PI_URAD
- One sub-module, argument_calc_mc_uc: the FSM, iteration counter, and busy/done/err.
- The top level holds the datapath: channel register array, work register, corrector.

## Test plan
- Reset: hold reset=0 with random inputs → argument=0, arg_ch=0, busy=0, done=0, err=0; accumulate ch2 delta=0 after release → argument=0.
- Load ch0 theta=1000000 delta=500000 → argument=1500000, arg_ch=0, done 2 cycles after start, err=0.
- Accumulate ch0 delta=2000000 → 3500000 corrected once → argument=-2783186, done 3 cycles after start.
- Channel isolation: load ch1 theta=-3000000 delta=-500000 → argument=2783186. Then accumulate ch0 delta=0 → -2783186 (ch0 untouched).
- Boundaries: load theta=3141593 delta=0 → -3141593. Load theta=-3141593 → -3141593. Op=10 on ch1 → 0.
- Errors: MAX_NORM_ITER=4, load theta=40000000 → done, err=1, argument unchanged. Also cover:
  - ch=CHANNELS → err=1 at ADD.
  - start pulsed while busy → ignored.
  - reset asserted during NORM → all zero, no write.
